operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue_pkg.sv | 30 +++
 rtl/operand_issue_regfile_8x.sv | 31 +++
 rtl/operand_issue.sv | 117 +++++++++++
 tb/tb_operand_issue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_pkg.sv
// Shared opcode codes and instruction field layout for the operand issue pipeline.
// Combinational definitions only; no latency.
// No flow control in this file.
package operand_issue_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_COM  = 3'd4,
        OP_MUL  = 3'd5,
        OP_ADDI = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    // Field positions: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] imm.
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] imm;
    } instr_t;

    function automatic logic writes_reg(input op_e op, input logic [2:0] rd);
        return (op != OP_NOP) && (rd != 3'd0);
    endfunction

endpackage

// File: rtl/operand_issue_regfile_8x.sv
// 8-entry register file, r0 hardwired to zero; 2 async read ports, 1 sync write port.
// Reads are combinational; writes land on the rising edge.
// No backpressure.
module regfile_8x #(
    parameter int DSIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ra1,
    input  logic [2:0]       ra2,
    output logic [DSIZE-1:0] rd1,
    output logic [DSIZE-1:0] rd2,
    input  logic             we,
    input  logic [2:0]       wa,
    input  logic [DSIZE-1:0] wd
);

    logic [DSIZE-1:0] mem [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we && (wa != 3'd0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 3'd0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == 3'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/operand_issue.sv
// Two-stage operand issue: ISS drives the external ALU, WB retires the result.
// Latency 2 edges from acceptance to res_valid; 1 instr/cycle sustained.
// res_ready low stalls WB then ISS; in_ready drops once both are occupied.
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int DSIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    output logic [DSIZE-1:0] alu_a,
    output logic [DSIZE-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [DSIZE-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_rd,
    output logic [DSIZE-1:0] res_data,
    output logic             res_we
);

    instr_t           ins;
    op_e              ins_op;
    op_e              iss_op;
    logic             iss_vld;
    logic             iss_we;
    logic [2:0]       iss_rd;
    logic             wb_fire;
    logic             iss_adv;
    logic             accept;
    logic [DSIZE-1:0] rf_rd1;
    logic [DSIZE-1:0] rf_rd2;
    logic [DSIZE-1:0] opa;
    logic [DSIZE-1:0] opb;

    assign ins    = instr_t'(in_instr);
    assign ins_op = op_e'(ins.op);

    assign wb_fire  = res_valid && res_ready;
    assign iss_adv  = iss_vld && (!res_valid || wb_fire);
    assign in_ready = rst_n && (!iss_vld || iss_adv);
    assign accept   = in_valid && in_ready;
    assign alu_op   = iss_op;

    regfile_8x #(.DSIZE(DSIZE)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ins.rs1),
        .ra2   (ins.rs2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wb_fire && res_we),
        .wa    (res_rd),
        .wd    (res_data)
    );

    // Youngest producer wins: ISS overrides WB overrides the register file.
    // A set we-flag already implies rd != 0, so r0 never forwards.
    always_comb begin
        opa = rf_rd1;
        opb = rf_rd2;
        if (res_valid && res_we && (res_rd == ins.rs1)) opa = res_data;
        if (res_valid && res_we && (res_rd == ins.rs2)) opb = res_data;
        if (iss_vld && iss_we && (iss_rd == ins.rs1))   opa = alu_out;
        if (iss_vld && iss_we && (iss_rd == ins.rs2))   opb = alu_out;
        if (ins_op == OP_ADDI)                          opb = DSIZE'(ins.imm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_vld <= 1'b0;
            iss_op  <= OP_NOP;
            iss_rd  <= 3'd0;
            iss_we  <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (accept) begin
            iss_vld <= 1'b1;
            iss_op  <= ins_op;
            iss_rd  <= ins.rd;
            iss_we  <= writes_reg(ins_op, ins.rd);
            alu_a   <= opa;
            alu_b   <= opb;
        end else if (iss_adv) begin
            // Empty ISS presents a NOP with zero operands to the ALU.
            iss_vld <= 1'b0;
            iss_op  <= OP_NOP;
            iss_rd  <= 3'd0;
            iss_we  <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_rd    <= 3'd0;
            res_data  <= '0;
            res_we    <= 1'b0;
        end else if (iss_adv) begin
            res_valid <= 1'b1;
            res_rd    <= iss_rd;
            res_data  <= alu_out;
            res_we    <= iss_we;
        end else if (wb_fire) begin
            res_valid <= 1'b0;
            res_rd    <= 3'd0;
            res_data  <= '0;
            res_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with DSIZE=4 and a behavioural ALU.
module tb_operand_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic [3:0]  alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_rd;
    logic [3:0]  res_data;
    logic        res_we;

    int n_chk;
    int n_fail;

    operand_issue #(.DSIZE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_rd    (res_rd),
        .res_data  (res_data),
        .res_we    (res_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: COM is the complement of operand a.
    always_comb begin
        case (alu_op)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a ^ alu_b;
            3'd4:    alu_out = ~alu_a;
            3'd5:    alu_out = alu_a * alu_b;
            3'd6:    alu_out = alu_a + alu_b;
            default: alu_out = 4'd0;
        endcase
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [3:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'd0;
        res_ready = 1'b1;

        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_alu_op", alu_op, 3'd7);
        chk("rst_alu_a", alu_a, 4'd0);
        chk("rst_res_we", res_we, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // ADDI r1,r0,5 ; ADD r2,r1,r1 back-to-back
        in_valid = 1'b1;
        in_instr = mk(3'd6, 3'd1, 3'd0, 3'd0, 4'd5);
        step();
        chk("addi_alu_op", alu_op, 3'd6);
        chk("addi_alu_a", alu_a, 4'd0);
        chk("addi_alu_b", alu_b, 4'd5);
        in_instr = mk(3'd0, 3'd2, 3'd1, 3'd1, 4'd0);
        step();
        chk("fwd_alu_a", alu_a, 4'd5);
        chk("fwd_alu_b", alu_b, 4'd5);
        chk("fwd_wb_rd", res_rd, 3'd1);
        chk("fwd_wb_data", res_data, 4'd5);
        in_valid = 1'b0;
        step();
        chk("fwd_r2_rd", res_rd, 3'd2);
        chk("fwd_r2_data", res_data, 4'd10);
        chk("fwd_r2_we", res_we, 1'b1);
        step();
        chk("idle_res_valid", res_valid, 1'b0);
        chk("idle_alu_op", alu_op, 3'd7);

        // Wrap: ADDI r1,r0,15 ; MUL r3,r1,r1 ; ADD r4,r1,r1
        in_valid = 1'b1;
        in_instr = mk(3'd6, 3'd1, 3'd0, 3'd0, 4'd15);
        step();
        in_instr = mk(3'd5, 3'd3, 3'd1, 3'd1, 4'd0);
        step();
        chk("mul_alu_a", alu_a, 4'd15);
        chk("mul_alu_b", alu_b, 4'd15);
        in_instr = mk(3'd0, 3'd4, 3'd1, 3'd1, 4'd0);
        step();
        chk("mul_res_rd", res_rd, 3'd3);
        chk("mul_res_data", res_data, 4'd1);
        chk("wbfwd_alu_a", alu_a, 4'd15);
        in_valid = 1'b0;
        step();
        chk("add_wrap_rd", res_rd, 3'd4);
        chk("add_wrap_data", res_data, 4'd14);
        step();
        // ADD r6,r3,r4 reads both from the register file
        in_valid = 1'b1;
        in_instr = mk(3'd0, 3'd6, 3'd3, 3'd4, 4'd0);
        step();
        chk("rf_alu_a", alu_a, 4'd1);
        chk("rf_alu_b", alu_b, 4'd14);
        in_valid = 1'b0;
        step();
        chk("rf_res_rd", res_rd, 3'd6);
        chk("rf_res_data", res_data, 4'd15);
        step();

        // r0: ADDI r0,r0,7 ; ADD r5,r0,r0
        in_valid = 1'b1;
        in_instr = mk(3'd6, 3'd0, 3'd0, 3'd0, 4'd7);
        step();
        in_instr = mk(3'd0, 3'd5, 3'd0, 3'd0, 4'd0);
        step();
        chk("r0_res_rd", res_rd, 3'd0);
        chk("r0_res_we", res_we, 1'b0);
        chk("r0_res_data", res_data, 4'd7);
        chk("r0_alu_a", alu_a, 4'd0);
        chk("r0_alu_b", alu_b, 4'd0);
        in_valid = 1'b0;
        step();
        chk("r5_res_rd", res_rd, 3'd5);
        chk("r5_res_data", res_data, 4'd0);
        chk("r5_res_we", res_we, 1'b1);
        step();

        // NOP never writes
        in_valid = 1'b1;
        in_instr = mk(3'd7, 3'd3, 3'd1, 3'd1, 4'd0);
        step();
        in_valid = 1'b0;
        step();
        chk("nop_res_valid", res_valid, 1'b1);
        chk("nop_res_we", res_we, 1'b0);
        step();

        // Backpressure: r1=15 r2=10 r3=1 r4=14 r5=0 r6=15 r7=0
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(3'd1, 3'd7, 3'd2, 3'd3, 4'd0);   // SUB r7,r2,r3 = 9
        step();
        chk("bp_in_ready_1", in_ready, 1'b1);
        in_instr = mk(3'd2, 3'd5, 3'd2, 3'd4, 4'd0);    // AND r5,r2,r4 = 10
        step();
        chk("bp_in_ready_2", in_ready, 1'b0);
        chk("bp_res_rd", res_rd, 3'd7);
        chk("bp_res_data", res_data, 4'd9);
        chk("bp_alu_a", alu_a, 4'd10);
        chk("bp_alu_b", alu_b, 4'd14);
        in_instr = mk(3'd3, 3'd6, 3'd2, 3'd4, 4'd0);    // XOR r6,r2,r4 = 4
        step();
        step();
        chk("bp_hold_in_ready", in_ready, 1'b0);
        chk("bp_hold_res_data", res_data, 4'd9);
        chk("bp_hold_alu_op", alu_op, 3'd2);
        chk("bp_hold_alu_b", alu_b, 4'd14);
        res_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        step();
        chk("bp_i2_rd", res_rd, 3'd5);
        chk("bp_i2_data", res_data, 4'd10);
        chk("bp_i3_alu_op", alu_op, 3'd3);
        chk("bp_i3_alu_a", alu_a, 4'd10);
        chk("bp_i3_alu_b", alu_b, 4'd14);
        in_instr = mk(3'd0, 3'd4, 3'd7, 3'd5, 4'd0);    // ADD r4,r7,r5 = 3
        step();
        chk("bp_i3_rd", res_rd, 3'd6);
        chk("bp_i3_data", res_data, 4'd4);
        chk("bp_i4_alu_a", alu_a, 4'd9);
        chk("bp_i4_alu_b", alu_b, 4'd10);
        in_valid = 1'b0;
        step();
        chk("bp_i4_rd", res_rd, 3'd4);
        chk("bp_i4_data", res_data, 4'd3);
        step();
        chk("bp_drained", res_valid, 1'b0);

        // COM r1,r4 = ~3 = 12
        in_valid = 1'b1;
        in_instr = mk(3'd4, 3'd1, 3'd4, 3'd0, 4'd0);
        step();
        chk("com_alu_op", alu_op, 3'd4);
        chk("com_alu_a", alu_a, 4'd3);
        in_valid = 1'b0;
        step();
        chk("com_res_rd", res_rd, 3'd1);
        chk("com_res_data", res_data, 4'd12);
        step();

        // Mid-stream reset with both stages occupied
        in_valid = 1'b1;
        in_instr = mk(3'd6, 3'd2, 3'd0, 3'd0, 4'd1);
        step();
        in_instr = mk(3'd6, 3'd3, 3'd0, 3'd0, 4'd2);
        step();
        in_valid = 1'b0;
        chk("pre_mrst_res_valid", res_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_res_valid", res_valid, 1'b0);
        chk("mrst_alu_op", alu_op, 3'd7);
        chk("mrst_in_ready", in_ready, 1'b0);
        chk("mrst_res_data", res_data, 4'd0);
        chk("mrst_alu_a", alu_a, 4'd0);
        step();
        #2;
        rst_n = 1'b1;
        #1;
        chk("mrst_release_in_ready", in_ready, 1'b1);
        for (int i = 1; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = mk(3'd0, 3'd0, 3'(i), 3'(i), 4'd0);
            step();
            chk("mrst_reg_a", alu_a, 4'd0);
            chk("mrst_reg_b", alu_b, 4'd0);
        end
        in_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
